// File: rtl/rgb_hue_fader_if.sv
// Purpose: bundles the rgb_hue_fader control input and LED/status outputs.
// Ports: mode (00 fade, 01 step, 10 hold, 11 off); RGB_R/G/B PWM drives;
//        seg (current hue segment 0..5); wrap (one-cycle pulse on seg 5->0).
interface rgb_hue_fader_if;
  logic [1:0] mode;
  logic       RGB_R;
  logic       RGB_G;
  logic       RGB_B;
  logic [2:0] seg;
  logic       wrap;

  // master: the fader itself (consumes mode, drives the LED pins and status)
  modport master (
    input  mode,
    output RGB_R, RGB_G, RGB_B, seg, wrap
  );

  // slave: whatever sets the mode and observes the LED/status lines
  modport slave (
    output mode,
    input  RGB_R, RGB_G, RGB_B, seg, wrap
  );
endinterface

// File: rtl/rgb_hue_fader.sv
// Purpose: sweeps an RGB LED around the six-segment hue wheel
//          (R->Y->G->C->B->M->R) with per-channel PWM so segments fade.
//          Modes: 00 fade, 01 hard step, 10 hold (frozen hue), 11 off.
// Ports:   clk, rst_n (async assert, active low); bus (master modport):
//          mode in, RGB_R/G/B out, seg[2:0] out, wrap out.
// Latency: one clock from pwm_cnt/duty/mode to RGB_*; outputs registered.
// Option:  define RGB_GAMMA_EN to square each duty ((d*d)>>PWM_BITS,
//          FULL kept at FULL) for perceptually linear fades, same latency.
module rgb_hue_fader #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 46875,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  rgb_hue_fader_if.master bus
);

  localparam int DW   = PWM_BITS + 1;         // duty range 0..FULL
  localparam int FULL = 1 << PWM_BITS;
  localparam int PS_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [DW-1:0]   DUTY_FULL = DW'(FULL);
  localparam logic [DW-1:0]   DUTY_ZERO = '0;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(STEP_CYCLES - 1);
  // XOR mask applied to the registered "on" bits; also the inactive level.
  localparam logic [2:0]      RGB_IDLE  = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    MODE_FADE = 2'b00,
    MODE_STEP = 2'b01,
    MODE_HOLD = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  mode_e mode_w;
  assign mode_w = mode_e'(bus.mode);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0]     presc_q,   presc_d;
  logic [PWM_BITS-1:0] ph_q,      ph_d;
  logic [2:0]          seg_q,     seg_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                wrap_q,    wrap_d;
  logic [2:0]          rgb_q,     rgb_d;

  logic presc_tc;
  logic ph_last;
  logic seg_last;

  assign presc_tc = (presc_q == PS_LAST);
  assign ph_last  = (ph_q == {PWM_BITS{1'b1}});
  assign seg_last = (seg_q == 3'd5);

  // PWM counter runs in every mode, including off.
  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

  // ---------------------------------------------------------------------------
  // Hue position: prescaler -> phase -> segment.
  // The mode input is used directly here, so a change to hold on the same
  // edge as a phase wrap discards the increment, and off wins over everything.
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d = presc_q;
    ph_d    = ph_q;
    seg_d   = seg_q;
    wrap_d  = 1'b0;
    unique case (mode_w)
      MODE_FADE, MODE_STEP: begin
        if (presc_tc) begin
          presc_d = '0;
          ph_d    = ph_q + PWM_BITS'(1);
          if (ph_last) begin
            if (seg_last) begin
              seg_d  = 3'd0;
              wrap_d = 1'b1;
            end else begin
              seg_d  = seg_q + 3'd1;
            end
          end
        end else begin
          presc_d = presc_q + PS_W'(1);
        end
      end
      MODE_HOLD: begin
        // position frozen; defaults already hold it
      end
      MODE_OFF: begin
        presc_d = '0;
        ph_d    = '0;
        seg_d   = 3'd0;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Duty generation.
  // Step mode reuses the fade table with the phase forced to zero: at ph=0
  // every segment's fade duty is exactly its start colour at 0/FULL levels.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ph_eff;
  logic [DW-1:0] duty_r, duty_g, duty_b;
  logic [DW-1:0] lvl_r,  lvl_g,  lvl_b;

  assign ph_eff = (mode_w == MODE_STEP) ? DUTY_ZERO : {1'b0, ph_q};

  always_comb begin
    duty_r = DUTY_ZERO;
    duty_g = DUTY_ZERO;
    duty_b = DUTY_ZERO;
    case (seg_q)
      3'd0: begin duty_r = DUTY_FULL;          duty_g = ph_eff;             duty_b = DUTY_ZERO;          end
      3'd1: begin duty_r = DUTY_FULL - ph_eff; duty_g = DUTY_FULL;          duty_b = DUTY_ZERO;          end
      3'd2: begin duty_r = DUTY_ZERO;          duty_g = DUTY_FULL;          duty_b = ph_eff;             end
      3'd3: begin duty_r = DUTY_ZERO;          duty_g = DUTY_FULL - ph_eff; duty_b = DUTY_FULL;          end
      3'd4: begin duty_r = ph_eff;             duty_g = DUTY_ZERO;          duty_b = DUTY_FULL;          end
      3'd5: begin duty_r = DUTY_FULL;          duty_g = DUTY_ZERO;          duty_b = DUTY_FULL - ph_eff; end
      default: begin
        // segments 6/7 are unreachable; leave the LED dark
      end
    endcase
  end

`ifdef RGB_GAMMA_EN
  // Squared duty, rescaled to the PWM range. d*d>>PWM_BITS already maps
  // FULL to FULL, the explicit test just keeps the intent obvious.
  function automatic logic [DW-1:0] gamma_f(input logic [DW-1:0] d);
    logic [2*DW-1:0] sq;
    logic [2*DW-1:0] sh;
    sq = {{DW{1'b0}}, d} * {{DW{1'b0}}, d};
    sh = sq >> PWM_BITS;
    if (d == DUTY_FULL) begin
      gamma_f = DUTY_FULL;
    end else begin
      gamma_f = sh[DW-1:0];
    end
  endfunction

  assign lvl_r = gamma_f(duty_r);
  assign lvl_g = gamma_f(duty_g);
  assign lvl_b = gamma_f(duty_b);
`else
  assign lvl_r = duty_r;
  assign lvl_g = duty_g;
  assign lvl_b = duty_b;
`endif

  // Channel on while pwm_cnt < duty: 0 never lights, FULL always lights.
  logic [DW-1:0] pwm_ext;
  assign pwm_ext = {1'b0, pwm_cnt_q};

  always_comb begin
    rgb_d = 3'b000;
    if (mode_w != MODE_OFF) begin
      rgb_d = {(pwm_ext < lvl_r), (pwm_ext < lvl_g), (pwm_ext < lvl_b)};
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      ph_q      <= '0;
      seg_q     <= 3'd0;
      pwm_cnt_q <= '0;
      wrap_q    <= 1'b0;
      rgb_q     <= RGB_IDLE;
    end else begin
      presc_q   <= presc_d;
      ph_q      <= ph_d;
      seg_q     <= seg_d;
      pwm_cnt_q <= pwm_cnt_d;
      wrap_q    <= wrap_d;
      rgb_q     <= rgb_d ^ RGB_IDLE;
    end
  end

  assign bus.RGB_R = rgb_q[2];
  assign bus.RGB_G = rgb_q[1];
  assign bus.RGB_B = rgb_q[0];
  assign bus.seg   = seg_q;
  assign bus.wrap  = wrap_q;

endmodule
